// File: rtl/vga_frame_capture.sv
// vga_frame_capture: captures a WIDTH x HEIGHT window of a VGA pixel stream
// into a frame RAM. Each pixel is packed to 8 bits (RGB 3:3:2) and written
// one clock after it is sampled. Supports single-shot and continuous capture.
module vga_frame_capture #(
  parameter int WIDTH   = 200,
  parameter int HEIGHT  = 200,
  parameter int X_START = 350,
  parameter int Y_START = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        arm,
  input  logic        cont,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Window bounds are 11 bits wide so X_START+WIDTH may exceed the 10-bit counter range.
  localparam logic [10:0] X_LO      = 11'(X_START);
  localparam logic [10:0] X_HI      = 11'(X_START + WIDTH);
  localparam logic [10:0] Y_LO      = 11'(Y_START);
  localparam logic [10:0] Y_HI      = 11'(Y_START + HEIGHT);
  localparam logic [15:0] LAST_ADDR = 16'(WIDTH * HEIGHT - 1);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;

  // RGB 3:3:2 packing of one pixel.
  function automatic logic [7:0] f_pack(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_hs;
  logic        r_vs;
  logic [9:0]  r_x_cnt;
  logic [9:0]  r_y_cnt;
  logic [15:0] r_addr;
  logic        w_hs_fall;
  logic        w_vs_fall;
  logic        w_in_win;
  logic        w_wr_go;

  assign w_hs_fall = r_hs & ~hsync;
  assign w_vs_fall = r_vs & ~vsync;
  assign w_in_win  = ({1'b0, r_x_cnt} >= X_LO) && ({1'b0, r_x_cnt} < X_HI) &&
                     ({1'b0, r_y_cnt} >= Y_LO) && ({1'b0, r_y_cnt} < Y_HI);
  // A vsync edge in CAPTURE restarts the frame, so it suppresses that cycle's write.
  assign w_wr_go   = (r_state == S_CAPTURE) && w_in_win && !w_vs_fall;

  // Sync registers and raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_x_cnt <= 10'd0;
      r_y_cnt <= 10'd0;
    end else begin
      r_hs <= hsync;
      r_vs <= vsync;
      if (w_hs_fall) begin
        r_x_cnt <= 10'd0;
      end else if (r_x_cnt != CNT_MAX) begin
        r_x_cnt <= r_x_cnt + 10'd1;
      end
      if (w_vs_fall) begin
        r_y_cnt <= 10'd0;
      end else if (w_hs_fall && (r_y_cnt != CNT_MAX)) begin
        r_y_cnt <= r_y_cnt + 10'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = arm ? S_WAIT_VS : S_IDLE;
      S_WAIT_VS: w_next = w_vs_fall ? S_CAPTURE : S_WAIT_VS;
      S_CAPTURE: w_next = (w_wr_go && (r_addr == LAST_ADDR)) ? S_DONE : S_CAPTURE;
      S_DONE:    w_next = (cont || arm) ? S_WAIT_VS : S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  // FSM status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_WAIT_VS: busy = 1'b1;
      S_CAPTURE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Address counter and sticky frame-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      if (((r_state == S_WAIT_VS) || (r_state == S_CAPTURE)) && w_vs_fall) begin
        r_addr <= 16'd0;
      end else if (w_wr_go) begin
        r_addr <= r_addr + 16'd1;
      end
      if ((r_state == S_IDLE) && arm) begin
        frame_err <= 1'b0;
      end else if ((r_state == S_CAPTURE) && w_vs_fall) begin
        frame_err <= 1'b1;
      end
    end
  end

  // Registered frame-RAM write port; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= 16'd0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= w_wr_go;
      if (w_wr_go) begin
        wr_addr <= r_addr;
        wr_data <= f_pack(pix_r, pix_g, pix_b);
      end
    end
  end

endmodule
